// File: rtl/mdu_iter_pkg.sv
// Shared MDU operation codes and decode helper for mdu_iter.
// MDU_MADD_EN widens MDUOp to 4 bits and adds the multiply-accumulate codes.
package mdu_iter_pkg;

`ifdef MDU_MADD_EN
    localparam int OP_W = 4;
`else
    localparam int OP_W = 3;
`endif

    localparam logic [OP_W-1:0] MDU_NOP   = OP_W'(0);
    localparam logic [OP_W-1:0] MDU_MULT  = OP_W'(1);
    localparam logic [OP_W-1:0] MDU_MULTU = OP_W'(2);
    localparam logic [OP_W-1:0] MDU_DIV   = OP_W'(3);
    localparam logic [OP_W-1:0] MDU_DIVU  = OP_W'(4);
    localparam logic [OP_W-1:0] MDU_MTHI  = OP_W'(5);
    localparam logic [OP_W-1:0] MDU_MTLO  = OP_W'(6);
`ifdef MDU_MADD_EN
    localparam logic [OP_W-1:0] MDU_MADD  = OP_W'(7);
    localparam logic [OP_W-1:0] MDU_MADDU = OP_W'(8);
    localparam logic [OP_W-1:0] MDU_MSUB  = OP_W'(9);
    localparam logic [OP_W-1:0] MDU_MSUBU = OP_W'(10);
`endif

    typedef struct packed {
        logic mul;
        logic div;
        logic sgn;
        logic mthi;
        logic mtlo;
`ifdef MDU_MADD_EN
        logic acc;
        logic sub;
`endif
    } mdu_dec_t;

    function automatic mdu_dec_t mdu_decode(input logic [OP_W-1:0] op);
        mdu_dec_t d;
        d = '0;
        case (op)
            MDU_MULT:  begin d.mul = 1'b1; d.sgn = 1'b1; end
            MDU_MULTU: d.mul = 1'b1;
            MDU_DIV:   begin d.div = 1'b1; d.sgn = 1'b1; end
            MDU_DIVU:  d.div = 1'b1;
            MDU_MTHI:  d.mthi = 1'b1;
            MDU_MTLO:  d.mtlo = 1'b1;
`ifdef MDU_MADD_EN
            MDU_MADD:  begin d.mul = 1'b1; d.sgn = 1'b1; d.acc = 1'b1; end
            MDU_MADDU: begin d.mul = 1'b1; d.acc = 1'b1; end
            MDU_MSUB:  begin d.mul = 1'b1; d.sgn = 1'b1; d.acc = 1'b1; d.sub = 1'b1; end
            MDU_MSUBU: begin d.mul = 1'b1; d.acc = 1'b1; d.sub = 1'b1; end
`endif
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement negation of a W-bit value.
module mdu_negate #(
    parameter int W = 64
) (
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    assign dout = en ? ((~din) + W'(1)) : din;

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit owning HI/LO: radix-2 shift-add multiply, restoring divide.
// MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU accumulation into {HI,LO}.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             Start,
    input  logic [OP_W-1:0]  MDUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             Busy,
    output logic             Done
);

    typedef enum logic [1:0] {
        MDU_S_IDLE,
        MDU_S_CALC,
        MDU_S_FIX
    } state_t;

    localparam int CW = $clog2(ITER) + 1;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    mdu_dec_t        dec;
    logic            accept, dz;
    logic            op_mul, neg_res, rem_neg;
`ifdef MDU_MADD_EN
    logic            op_acc, op_sub;
`endif

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   acc, q, opnd;
    logic [WIDTH:0]     mul_sum, part;
    logic [WIDTH-1:0]   diff;
    logic               ge;
    logic [2*WIDTH-1:0] fix_in, fix_out, hilo_new;
    logic [WIDTH-1:0]   rem_out;

    always_comb begin
        dec    = mdu_decode(MDUOp);
        accept = (state == MDU_S_IDLE) && Start && (dec.mul || dec.div);
        dz     = dec.div && (B == '0);
    end

    mdu_negate #(.W(WIDTH)) u_neg_a (.en(dec.sgn & A[WIDTH-1]), .din(A), .dout(a_mag));
    mdu_negate #(.W(WIDTH)) u_neg_b (.en(dec.sgn & B[WIDTH-1]), .din(B), .dout(b_mag));

    // One iteration step: mul adds into the upper half and shifts right; div trial-subtracts.
    always_comb begin
        mul_sum = {1'b0, acc} + (q[0] ? {1'b0, opnd} : '0);
        part    = {acc, q[WIDTH-1]};
        ge      = (part >= {1'b0, opnd});
        diff    = part[WIDTH-1:0] - opnd;
    end

    always_comb begin
        fix_in = op_mul ? {acc, q} : {{WIDTH{1'b0}}, q};
    end

    mdu_negate #(.W(2*WIDTH)) u_neg_fix (.en(neg_res), .din(fix_in), .dout(fix_out));
    mdu_negate #(.W(WIDTH))   u_neg_rem (.en(rem_neg), .din(acc),    .dout(rem_out));

    always_comb begin
        hilo_new = op_mul ? fix_out : {rem_out, fix_out[WIDTH-1:0]};
`ifdef MDU_MADD_EN
        if (op_acc) begin
            hilo_new = op_sub ? ({HI, LO} - fix_out) : ({HI, LO} + fix_out);
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MDU_S_IDLE: if (accept) state_nxt = dz ? MDU_S_FIX : MDU_S_CALC;
            MDU_S_CALC: if (cnt == CW'(ITER - 1)) state_nxt = MDU_S_FIX;
            MDU_S_FIX:  state_nxt = MDU_S_IDLE;
            default:    state_nxt = MDU_S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= MDU_S_IDLE;
            cnt     <= '0;
            HI      <= '0;
            LO      <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            op_mul  <= 1'b0;
            neg_res <= 1'b0;
            rem_neg <= 1'b0;
`ifdef MDU_MADD_EN
            op_acc  <= 1'b0;
            op_sub  <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            Busy  <= (state_nxt != MDU_S_IDLE);
            Done  <= (state == MDU_S_FIX);
            cnt   <= (state == MDU_S_CALC) ? cnt + CW'(1) : '0;
            if (accept) begin
                op_mul  <= dec.mul;
                neg_res <= dec.sgn & (A[WIDTH-1] ^ B[WIDTH-1]) & ~dz;
                rem_neg <= dec.div & dec.sgn & A[WIDTH-1] & ~dz;
`ifdef MDU_MADD_EN
                op_acc  <= dec.acc;
                op_sub  <= dec.sub;
`endif
            end
            if (state == MDU_S_FIX) begin
                {HI, LO} <= hilo_new;
            end else if ((state == MDU_S_IDLE) && Start) begin
                if (dec.mthi) HI <= A;
                if (dec.mtlo) LO <= A;
            end
        end
    end

    // Divide-by-zero preloads the fixed result and skips CALC.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (dz) begin
                acc  <= A;
                q    <= '1;
                opnd <= '0;
            end else if (dec.mul) begin
                acc  <= '0;
                q    <= b_mag;
                opnd <= a_mag;
            end else begin
                acc  <= '0;
                q    <= a_mag;
                opnd <= b_mag;
            end
        end else if (state == MDU_S_CALC) begin
            if (op_mul) begin
                acc <= mul_sum[WIDTH:1];
                q   <= {mul_sum[0], q[WIDTH-1:1]};
            end else begin
                acc <= ge ? diff : part[WIDTH-1:0];
                q   <= {q[WIDTH-2:0], ge};
            end
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: scoreboard of expected HI/LO and result latency.
`timescale 1ns/1ps
module tb_mdu_iter;
    import mdu_iter_pkg::*;

    logic            clk   = 1'b0;
    logic            rstn  = 1'b1;
    logic            Start = 1'b0;
    logic [OP_W-1:0] MDUOp = '0;
    logic [31:0]     A     = '0;
    logic [31:0]     B     = '0;
    logic [31:0]     HI, LO;
    logic            Busy, Done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat_min;
        int          lat_max;
    } exp_t;
    exp_t sb[$];

    mdu_iter #(.WIDTH(32), .ITER(32)) dut (
        .clk(clk), .rstn(rstn), .Start(Start), .MDUOp(MDUOp),
        .A(A), .B(B), .HI(HI), .LO(LO), .Busy(Busy), .Done(Done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [OP_W-1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        Start = 1'b1; MDUOp = op; A = a; B = b;
        @(negedge clk);
        Start = 1'b0; MDUOp = MDU_NOP; A = $urandom; B = $urandom;
    endtask

    // n0 = negedges already elapsed since the acceptance edge
    task automatic collect(input string tag, input int n0);
        int   n;
        exp_t e;
        n = n0;
        while (Done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_sb"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check({tag, "_lat"}, 64'(n >= e.lat_min && n <= e.lat_max), 64'd1);
        check({tag, "_hi"}, {32'd0, HI}, {32'd0, e.hi});
        check({tag, "_lo"}, {32'd0, LO}, {32'd0, e.lo});
        @(negedge clk);
        check({tag, "_pulse"}, {62'd0, Done, Busy}, 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [OP_W-1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input int lmin, input int lmax);
        sb.push_back('{ehi, elo, lmin, lmax});
        issue(op, a, b);
        check({tag, "_busy"}, {63'd0, Busy}, 64'd1);
        collect(tag, 0);
    endtask

    initial begin
        logic [31:0] ra, rb, hold_hi, hold_lo;
        longint      p;
        int          dcount;

        #2 rstn = 1'b0;
        repeat (2) @(negedge clk);
        check("reset", {HI, LO}, 64'd0);
        check("reset_ctl", {62'd0, Busy, Done}, 64'd0);
        rstn = 1'b1;

`ifdef MDU_MADD_EN
        @(negedge clk); Start = 1'b1; MDUOp = MDU_MTLO; A = 32'd5;
        @(negedge clk); Start = 1'b0;
        run_op("madd", MDU_MADD, 32'd2, 32'd3, 32'd0, 32'd11, 33, 33);
        run_op("msubu", MDU_MSUBU, 32'd4, 32'd4, 32'hFFFFFFFF, 32'hFFFFFFFB, 33, 33);
`endif

        run_op("mult_neg", MDU_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, 33);
        run_op("multu_max", MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 33);
        run_op("div_neg", MDU_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 33);
        run_op("divu", MDU_DIVU, 32'hFFFFFFFF, 32'd16, 32'h0000000F, 32'h0FFFFFFF, 33, 33);
        run_op("div_zero", MDU_DIV, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF, 1, 2);
        run_op("div_ovf", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 33, 33);

        for (int i = 0; i < 3; i++) begin
            ra = $urandom; rb = $urandom;
            p  = longint'($signed(ra)) * longint'($signed(rb));
            run_op("mult_rnd", MDU_MULT, ra, rb, p[63:32], p[31:0], 33, 33);
            rb = $urandom_range(1, 32'h0000FFFF);
            run_op("divu_rnd", MDU_DIVU, ra, rb, ra % rb, ra / rb, 33, 33);
        end

        // MTHI/MTLO act immediately and never raise Busy or Done.
        @(negedge clk); Start = 1'b1; MDUOp = MDU_MTHI; A = 32'h00005555;
        @(negedge clk); Start = 1'b0;
        check("mthi", {32'd0, HI}, 64'h5555);
        check("mthi_ctl", {62'd0, Busy, Done}, 64'd0);
        @(negedge clk); Start = 1'b1; MDUOp = MDU_MTLO; A = 32'h0000AAAA;
        @(negedge clk); Start = 1'b0;
        check("mtlo", {HI, LO}, 64'h00005555_0000AAAA);

        hold_hi = HI; hold_lo = LO;
        @(negedge clk); Start = 1'b1; MDUOp = MDU_NOP; A = 32'h1; B = 32'h1;
        @(negedge clk); MDUOp = '1;
        @(negedge clk); Start = 1'b0;
        check("nop_undef", {HI, LO}, {hold_hi, hold_lo});
        check("nop_ctl", {62'd0, Busy, Done}, 64'd0);

        // Start while busy is ignored.
        sb.push_back('{32'd0, 32'd30, 33, 33});
        issue(MDU_MULT, 32'd5, 32'd6);
        repeat (8) @(negedge clk);
        Start = 1'b1; MDUOp = MDU_MTLO; A = 32'h000000AA;
        @(negedge clk);
        Start = 1'b0; MDUOp = MDU_NOP;
        check("ign_busy", {63'd0, Busy}, 64'd1);
        collect("ignore", 9);

        // Asynchronous reset mid-operation.
        issue(MDU_MULT, 32'd5, 32'd6);
        repeat (19) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("abort_hilo", {HI, LO}, 64'd0);
        check("abort_ctl", {62'd0, Busy, Done}, 64'd0);
        @(negedge clk); rstn = 1'b1;
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Done || Busy) dcount++;
        end
        check("abort_quiet", 64'(dcount), 64'd0);
        check("abort_result", {HI, LO}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
